// File: rtl/wishbone_rr_arbiter_pkg.sv
// wishbone_rr_arbiter_pkg
//   Shared types and helpers for the round-robin Wishbone arbiter.
//   - state_e   : arbiter FSM states (ABORT is only reachable when the
//                 WB_RR_ARBITER_TIMEOUT_EN watchdog is compiled in).
//   - idx_width : width of a master index, clog2(NUM) with a floor of 1.
package wishbone_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wishbone_rr_pick.sv
// wishbone_rr_pick
//   Combinational rotate-priority encoder. Scans last+1, last+2, ...
//   modulo NUM and returns the first requesting index.
// Ports:
//   req  in  NUM  request vector
//   last in  IW   index served most recently
//   gnt  out IW   chosen index (0 when no request)
//   any  out 1    at least one request is present
module wishbone_rr_pick
  import wishbone_rr_arbiter_pkg::*;
#(
  parameter int NUM = 4,
  parameter int IW  = idx_width(NUM)
) (
  input  logic [NUM-1:0] req,
  input  logic [IW-1:0]  last,
  output logic [IW-1:0]  gnt,
  output logic           any
);

  logic [IW-1:0] idx_s;

  // Scan from furthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    gnt   = {IW{1'b0}};
    any   = 1'b0;
    idx_s = {IW{1'b0}};
    for (int k = NUM; k >= 1; k--) begin
      idx_s = IW'((int'(last) + k) % NUM);
      if (req[idx_s]) begin
        gnt = idx_s;
        any = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// wishbone_rr_arbiter
//   Round-robin arbiter sharing one Wishbone classic slave port among NUM
//   masters. One master is granted at a time; the grant is held until the
//   slave acks, and ack/read data are routed back to the granted master.
//   Optional watchdog (compile with WB_RR_ARBITER_TIMEOUT_EN) releases a
//   master whose access is never acknowledged after TIMEOUT BUSY cycles.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_wb_adr/dat/sel/we_i  per-master payload, master i at slice i
//   s_wb_stb_i             per-master request
//   s_wb_dat_o             read data shared by all masters
//   s_wb_ack_o             one-hot ack to the granted master
//   m_wb_adr/dat/sel/we_o  payload muxed from the granted master
//   m_wb_stb_o             strobe to the slave, decoded from state only
//   m_wb_dat_i, m_wb_ack_i response from the slave
//   timeout_o              sticky watchdog flag (0 without the macro)
module wishbone_rr_arbiter
  import wishbone_rr_arbiter_pkg::*;
#(
  parameter int NUM       = 4,
  parameter int ADR_WIDTH = 37,
  parameter int DAT_SIZE  = 3,
  parameter int TIMEOUT   = 1024
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM*ADR_WIDTH-1:0]         s_wb_adr_i,
  input  logic [NUM*(8<<DAT_SIZE)-1:0]     s_wb_dat_i,
  input  logic [NUM*(1<<DAT_SIZE)-1:0]     s_wb_sel_i,
  input  logic [NUM-1:0]                   s_wb_we_i,
  input  logic [NUM-1:0]                   s_wb_stb_i,
  output logic [(8<<DAT_SIZE)-1:0]         s_wb_dat_o,
  output logic [NUM-1:0]                   s_wb_ack_o,
  output logic [ADR_WIDTH-1:0]             m_wb_adr_o,
  output logic [(8<<DAT_SIZE)-1:0]         m_wb_dat_o,
  output logic [(1<<DAT_SIZE)-1:0]         m_wb_sel_o,
  output logic                             m_wb_we_o,
  output logic                             m_wb_stb_o,
  input  logic [(8<<DAT_SIZE)-1:0]         m_wb_dat_i,
  input  logic                             m_wb_ack_i,
  output logic                             timeout_o
);

  localparam int DW = 8 << DAT_SIZE;
  localparam int SW = 1 << DAT_SIZE;
  localparam int IW = idx_width(NUM);

  state_e        state_r, state_nx;
  logic [IW-1:0] gnt_r, gnt_nx;
  logic [IW-1:0] last_r, last_nx;
  logic [IW-1:0] pick_gnt_s;
  logic          pick_any_s;
  logic          fire_s;

  wishbone_rr_pick #(
    .NUM (NUM),
    .IW  (IW)
  ) u_pick (
    .req  (s_wb_stb_i),
    .last (last_r),
    .gnt  (pick_gnt_s),
    .any  (pick_any_s)
  );

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] wdog_r, wdog_nx;
  logic          timeout_r;

  // Watchdog expires on the last allowed BUSY cycle; a real ack that same
  // cycle wins and is treated as a normal completion.
  assign fire_s = (state_r == ST_BUSY) && !m_wb_ack_i &&
                  (wdog_r == CW'(TIMEOUT - 1));

  // Watchdog count: runs only in BUSY, zero everywhere else so it is clear on entry.
  always_comb begin
    wdog_nx = {CW{1'b0}};
    if (state_r == ST_BUSY) begin
      wdog_nx = wdog_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      wdog_nx = {CW{1'b0}};
    end
  end

  // Watchdog counter and sticky timeout flag registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wdog_r    <= {CW{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      wdog_r <= wdog_nx;
      if (fire_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_r;
`else
  assign fire_s    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state logic: grant in IDLE, complete on ack in BUSY/ABORT.
  always_comb begin
    state_nx = state_r;
    gnt_nx   = gnt_r;
    last_nx  = last_r;
    case (state_r)
      ST_IDLE: begin
        // m_wb_ack_i is deliberately ignored here.
        if (pick_any_s) begin
          state_nx = ST_BUSY;
          gnt_nx   = pick_gnt_s;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (m_wb_ack_i) begin
          state_nx = ST_IDLE;
          last_nx  = gnt_r;
        end else if (fire_s) begin
          state_nx = ST_ABORT;
        end else begin
          state_nx = ST_BUSY;
        end
      end
      ST_ABORT: begin
        // Strobe stays up until the slave finally acks; that ack is swallowed.
        if (m_wb_ack_i) begin
          state_nx = ST_IDLE;
          last_nx  = gnt_r;
        end else begin
          state_nx = ST_ABORT;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // FSM, grant and last-served registers; last resets to NUM-1 so master 0 goes first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
      gnt_r   <= {IW{1'b0}};
      last_r  <= IW'(NUM - 1);
    end else begin
      state_r <= state_nx;
      gnt_r   <= gnt_nx;
      last_r  <= last_nx;
    end
  end

  // Strobe is a pure state decode so a retracted master stb never reaches the slave.
  assign m_wb_stb_o = (state_r != ST_IDLE);

  assign m_wb_adr_o = s_wb_adr_i[int'(gnt_r)*ADR_WIDTH +: ADR_WIDTH];
  assign m_wb_dat_o = s_wb_dat_i[int'(gnt_r)*DW +: DW];
  assign m_wb_sel_o = s_wb_sel_i[int'(gnt_r)*SW +: SW];
  assign m_wb_we_o  = s_wb_we_i[gnt_r];

  // A watchdog release returns zero data to the master instead of bus data.
  assign s_wb_dat_o = fire_s ? {DW{1'b0}} : m_wb_dat_i;

  // Zero-latency ack steering to the granted master, only while BUSY.
  always_comb begin
    s_wb_ack_o = {NUM{1'b0}};
    if ((state_r == ST_BUSY) && (m_wb_ack_i || fire_s)) begin
      s_wb_ack_o[gnt_r] = 1'b1;
    end else begin
      s_wb_ack_o = {NUM{1'b0}};
    end
  end

endmodule

// File: doc/wishbone_rr_arbiter.md
# wishbone_rr_arbiter

Round-robin arbiter that shares one Wishbone classic slave port, the 37-bit, 64-bit-data Wishbone side of the Wishbone-to-AXI4-Lite peripheral bridge, among NUM Wishbone masters. Typical masters are a debug/host access path and on-chip sequencers. It grants one master at a time, holds the grant until the slave acks, and routes read data and ack back to the granted master. An optional watchdog releases a master whose access is never acknowledged.

## Interface
- NUM, 4: number of masters (2..16).
- ADR_WIDTH, 37: word address width.
- DAT_SIZE, 3: data width is 8<<DAT_SIZE bits (DW); SEL width is DW/8 (SW).
- TIMEOUT, 1024: cycles in BUSY before watchdog abort (≥2; used only with the macro).

- aclk  in  1  sole clock.
- aresetn  in  1  asynchronous, active-low reset.
- s_wb_adr_i  in  NUM*ADR_WIDTH  master addresses, master i at slice i.
- s_wb_dat_i  in  NUM*DW  master write data.
- s_wb_sel_i  in  NUM*SW  byte selects.
- s_wb_we_i  in  NUM  write enables.
- s_wb_stb_i  in  NUM  requests.
- s_wb_dat_o  out  DW  read data, shared by all masters; valid with the ack.
- s_wb_ack_o  out  NUM  one-hot ack to the granted master.
- m_wb_adr_o  out  ADR_WIDTH  to bridge.
- m_wb_dat_o  out  DW  to bridge.
- m_wb_sel_o  out  SW  to bridge.
- m_wb_we_o  out  1  to bridge.
- m_wb_stb_o  out  1  to bridge.
- m_wb_dat_i  in  DW  from bridge.
- m_wb_ack_i  in  1  from bridge.
- timeout_o  out  1  sticky watchdog flag.

## Operation
- States: IDLE, BUSY, ABORT. Registers: state, grant index (gnt), last-served index (last).
- IDLE: if any s_wb_stb_i is set, choose the first requester scanning last+1, last+2, … modulo NUM. Load gnt and go to BUSY. With no request, stay in IDLE.
- BUSY:
  - m_wb_stb_o=1.
  - m_wb_adr/dat/sel/we are muxed combinationally from slice gnt.
  - s_wb_ack_o[gnt]=m_wb_ack_i, combinational.
  - s_wb_dat_o=m_wb_dat_i.
  - On m_wb_ack_i: last←gnt, go to IDLE.
- A master is granted with stb high and must hold stb and payload until its ack. If stb drops while granted, the transfer is still completed to the slave and the ack is still delivered.
- m_wb_stb_o is driven from state, never from s_wb_stb_i, so the bridge never sees a retracted strobe.
- ABORT (macro only):
  - m_wb_stb_o=1 and the payload stays muxed from gnt.
  - s_wb_ack_o=0.
  - The next m_wb_ack_i is discarded. Then last←gnt, go to IDLE.
- Outside an active ack: s_wb_dat_o is the muxed m_wb_dat_i and s_wb_ack_o=0.

## Timing
- Reset values: state=IDLE, gnt=0, last=NUM-1 (master 0 has first priority), timeout_o=0, m_wb_stb_o=0, s_wb_ack_o=0, watchdog counter=0. The m_wb payload outputs show slice 0.
- Reset asserted mid-access aborts the access immediately. The bridge must share the same reset.
- Request latency: stb sampled high in cycle c → m_wb_stb_o high in cycle c+1.
- Ack latency is zero: the master sees its ack in the same cycle as m_wb_ack_i.
- The ack cycle is followed by exactly one IDLE cycle before the next grant. Back-to-back grants therefore have m_wb_stb_o low for one cycle. A stale stb in the ack cycle is never re-granted.
- Simultaneous requests are served in rotation. With all NUM requesting continuously, each master is served once per NUM grants.
- m_wb_ack_i is ignored in IDLE.

## Configuration
- WB_RR_ARBITER_TIMEOUT_EN defined:
  - A counter runs in BUSY and clears on entering BUSY.
  - If it reaches TIMEOUT-1 without an ack: s_wb_ack_o[gnt]=1 for that cycle with s_wb_dat_o=0, timeout_o←1 (sticky until reset), state→ABORT.
  - An ack arriving in the same cycle takes priority as a normal completion.
- Undefined: no counter, no ABORT state, timeout_o tied 0. BUSY waits indefinitely.

## Structure
- Package wishbone_rr_arbiter_pkg:
  - state enum (IDLE, BUSY, ABORT).
  - localparam function for the index width, clog2(NUM).
- One sub-module, wishbone_rr_pick: combinational rotate-priority encoder. Inputs: request vector and last index. Outputs: grant index and any-request flag.

## Test plan
- Single master 2 write, adr 0x0_0000_0010, dat 0xDEAD_BEEF_0123_4567, sel 0xFF, slave acks 3 cycles after stb: m_wb payload matches, s_wb_ack_o=4'b0100 for one cycle, no other acks.
- Read by master 1, slave returns 0x1122_3344_5566_7788: s_wb_dat_o equals that value in the ack cycle.
- All 4 masters request continuously from reset, slave acks after 1 cycle: grant order 0,1,2,3,0,1 with one idle cycle between grants.
- Masters 1 and 3 request after master 3 was last served: master 0 has no request, so master 1 is granted first, then master 3.
- aresetn pulsed low while BUSY: outputs return to their reset values asynchronously, and the next request is granted to master 0 first.
- Macro defined, TIMEOUT=16, slave never acks: master acked with dat 0 in the 16th BUSY cycle and timeout_o=1. A late slave ack is discarded, and the next request is then served normally.
